// File: rtl/nco_sincos_if.sv
`default_nettype none
// ============================================================================
// Module   : nco_sincos_if
// Purpose  : Control, phase and quadrature-output bundle for nco_sincos.
// Revision : 1.0
// ============================================================================
interface nco_sincos_if #(
  parameter int W = 16,
  parameter int P = 16
);
  logic         ce;
  logic         mode;
  logic         in_valid;
  logic [P-1:0] phase_in;
  logic [P-1:0] freq;
  logic         load;
  logic         out_valid;
  logic [W-1:0] cos_out;
  logic [W-1:0] sin_out;

  modport master (
    output ce, mode, in_valid, phase_in, freq, load,
    input  out_valid, cos_out, sin_out
  );

  modport slave (
    input  ce, mode, in_valid, phase_in, freq, load,
    output out_valid, cos_out, sin_out
  );
endinterface
`default_nettype wire

// File: rtl/nco_sincos.sv
`default_nettype none
// ============================================================================
// Module   : nco_sincos
// Purpose  : Phase-to-cos/sin converter and NCO, quarter-wave table with
//            linear interpolation, 5-stage ce-gated pipeline.
// Revision : 1.0
// ============================================================================
module nco_sincos #(
  parameter int W = 16,
  parameter int P = 16,
  parameter int L = 6
) (
  input  logic        clk,
  input  logic        reset,
  nco_sincos_if.slave bus
);
  localparam int c_frac_w  = P - 2 - L;
  localparam int c_n       = 1 << L;
  localparam int c_full    = (1 << (W - 1)) - 1;
  localparam int c_prod_w  = W - 1 + c_frac_w;
  localparam int c_quarter = 1 << (P - 2);

  // Elaboration-time cosine via Taylor series; angle never exceeds pi/2.
  function automatic int table_entry(input int k);
    real ang, term, sum;
    int  res;
    ang  = 3.14159265358979323846 * real'(k) / real'(2 * c_n);
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n <= 14; n++) begin
      term = -term * ang * ang / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    if (k >= c_n) res = 0;
    else          res = $rtoi(sum * real'(c_full) + 0.5);
    table_entry = res;
  endfunction

  logic [W-2:0] cos_table [0:c_n];

  generate
    for (genvar k = 0; k <= c_n; k++) begin : g_table
      localparam int c_entry = table_entry(k);
      assign cos_table[k] = (W-1)'(c_entry);
    end
  endgenerate

  // Stage 0: phase source selection and accumulator
  logic [P-1:0] acc_q, acc_d;
  logic [P-1:0] ph0_q, ph0_d;
  logic [5:0]   vld_q, vld_d;

  always_comb begin
    acc_d = acc_q;
    ph0_d = ph0_q;
    vld_d = vld_q;
    if (bus.ce) begin
      if (bus.mode) begin
        acc_d = bus.load ? bus.phase_in : acc_q + bus.freq;
      end
      ph0_d = bus.mode ? acc_q : bus.phase_in;
      vld_d = {vld_q[4:0], bus.mode | bus.in_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      vld_q <= '0;
    end else begin
      acc_q <= acc_d;
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    ph0_q <= ph0_d;
  end

  logic [W-1:0] chan_out [2];

  generate
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      logic [P-1:0]          ph_w;
      logic [P-2:0]          fold_w;
      logic [L:0]            idx_nxt_w;
      logic [L:0]            idx1_q, idx1_d;
      logic [c_frac_w-1:0]   frac1_q, frac1_d;
      logic [c_frac_w-1:0]   frac2_q, frac2_d;
      logic [4:1]            neg_q, neg_d;
      logic [W-2:0]          t2_q, t2_d;
      logic [W-2:0]          dif2_q, dif2_d;
      logic [W-2:0]          t3_q, t3_d;
      logic [c_prod_w-1:0]   prod3_q, prod3_d;
      logic [W-2:0]          mag4_q, mag4_d;
      logic [W-1:0]          out_q, out_d;

      always_comb begin
        ph_w      = (ch == 0) ? ph0_q : ph0_q - P'(c_quarter);
        // Upper half of |phase| reflects about 0.5; the fold lands in [0, 0.5].
        fold_w    = ph_w[P-2] ? -ph_w[P-2:0] : ph_w[P-2:0];
        idx_nxt_w = (idx1_q == (L+1)'(c_n)) ? idx1_q : idx1_q + 1'b1;

        idx1_d  = idx1_q;
        frac1_d = frac1_q;
        frac2_d = frac2_q;
        neg_d   = neg_q;
        t2_d    = t2_q;
        dif2_d  = dif2_q;
        t3_d    = t3_q;
        prod3_d = prod3_q;
        mag4_d  = mag4_q;
        out_d   = out_q;
        if (bus.ce) begin
          idx1_d  = fold_w[P-2:c_frac_w];
          frac1_d = fold_w[c_frac_w-1:0];
          neg_d   = {neg_q[3:1], ph_w[P-1] ^ ph_w[P-2]};
          t2_d    = cos_table[idx1_q];
          dif2_d  = cos_table[idx1_q] - cos_table[idx_nxt_w];
          frac2_d = frac1_q;
          prod3_d = c_prod_w'(dif2_q) * c_prod_w'(frac2_q);
          t3_d    = t2_q;
          mag4_d  = t3_q - prod3_q[c_prod_w-1:c_frac_w];
          out_d   = neg_q[4] ? -{1'b0, mag4_q} : {1'b0, mag4_q};
        end
      end

      always_ff @(posedge clk) begin
        idx1_q  <= idx1_d;
        frac1_q <= frac1_d;
        frac2_q <= frac2_d;
        neg_q   <= neg_d;
        t2_q    <= t2_d;
        dif2_q  <= dif2_d;
        t3_q    <= t3_d;
        prod3_q <= prod3_d;
        mag4_q  <= mag4_d;
      end

      always_ff @(posedge clk) begin
        if (reset) out_q <= '0;
        else       out_q <= out_d;
      end

      assign chan_out[ch] = out_q;
    end
  endgenerate

  assign bus.out_valid = vld_q[5];
  assign bus.cos_out   = chan_out[0];
  assign bus.sin_out   = chan_out[1];
endmodule
`default_nettype wire

// File: tb/tb_nco_sincos.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_sincos
// Purpose  : Scoreboard bench for nco_sincos against an arithmetic reference.
// Revision : 1.0
// ============================================================================
module tb_nco_sincos;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset;

  nco_sincos_if #(.W(16), .P(16)) bus ();

  nco_sincos #(.W(16), .P(16), .L(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ph;
    logic [15:0] ec;
    logic [15:0] es;
    int          stamp;
  } sb_t;

  sb_t         sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_ce     = 0;
  int          ce_cnt   = 0;
  logic [15:0] acc_m    = 16'h0000;
  int          tab [0:64];

  // Reference: fold |phase| into [0, 0.5] of pi, interpolate between
  // rounded cosine samples spaced pi/128 apart.
  function automatic logic [15:0] ref_cos(input logic [15:0] ph);
    int p, a, x, i, f, t0, t1, mag;
    bit neg;
    p   = int'($signed(ph));
    a   = (p < 0) ? -p : p;
    neg = (a > 16384);
    x   = neg ? 32768 - a : a;
    i   = x / 256;
    f   = x % 256;
    t0  = tab[i];
    t1  = (i < 64) ? tab[i + 1] : 0;
    mag = t0 - ((t0 - t1) * f) / 256;
    ref_cos = 16'(neg ? -mag : mag);
  endfunction

  function automatic int ideal(input logic [15:0] ph, input bit is_sin);
    real ang;
    ang = PI * real'(int'($signed(ph))) / 32768.0;
    ideal = is_sin ? int'($sin(ang) * 32767.0) : int'($cos(ang) * 32767.0);
  endfunction

  task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_err(input string nm, input logic [15:0] got, input int id);
    int d;
    n_checks++;
    d = int'($signed(got)) - id;
    if (d > 4 || d < -4 || got == 16'h8000) begin
      n_fail++;
      $display("FAIL %s: got %h ideal %0d (needs |err|<=4, not 8000)", nm, got, id);
    end
  endtask

  task automatic push(input logic [15:0] ph, input int stamp);
    sb_t e;
    e.ph    = ph;
    e.ec    = ref_cos(ph);
    e.es    = ref_cos(ph - 16'h4000);
    e.stamp = stamp;
    sb.push_back(e);
  endtask

  task automatic step(input bit c, input bit m, input bit iv, input logic [15:0] ph,
                      input logic [15:0] fr, input bit ld);
    logic [15:0] samp;
    bit          v;
    @(negedge clk);
    bus.ce = c; bus.mode = m; bus.in_valid = iv;
    bus.phase_in = ph; bus.freq = fr; bus.load = ld;
    if (c) begin
      n_ce++;
      if (m) begin
        samp  = acc_m;
        v     = 1'b1;
        acc_m = ld ? ph : acc_m + fr;
      end else begin
        samp = ph;
        v    = iv;
      end
      if (v) push(samp, n_ce);
    end
  endtask

  task automatic step_const(input logic [15:0] ph, input logic [15:0] ec, input logic [15:0] es);
    step(1'b1, 1'b0, 1'b1, ph, 16'h0, 1'b0);
    sb[$].ec = ec;
    sb[$].es = es;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset  = 1'b1;
      bus.ce = 1'($urandom_range(0, 1));
      sb.delete();
      acc_m  = 16'h0000;
      @(posedge clk);
      #1;
      chk16("rst_out_valid", 16'(bus.out_valid), 16'h0);
      chk16("rst_cos", bus.cos_out, 16'h0);
      chk16("rst_sin", bus.sin_out, 16'h0);
    end
    @(negedge clk);
    reset    = 1'b0;
    bus.ce   = 1'b0;
  endtask

  // Monitor: pops one entry per presented output, checks data and latency.
  initial begin : monitor
    bit  ce_e, rst_e;
    sb_t e;
    forever begin
      @(posedge clk);
      ce_e  = bus.ce;
      rst_e = reset;
      #1;
      if (!rst_e && ce_e) begin
        ce_cnt++;
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got out_valid=1 expected 0 (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk_int("latency", ce_cnt - e.stamp, 5);
            chk16("cos", bus.cos_out, e.ec);
            chk16("sin", bus.sin_out, e.es);
            chk_err("cos_err", bus.cos_out, ideal(e.ph, 1'b0));
            chk_err("sin_err", bus.sin_out, ideal(e.ph, 1'b1));
          end
        end else if (sb.size() != 0 && sb[0].stamp + 5 <= ce_cnt) begin
          e = sb.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missing_valid: got out_valid=0 expected 1 for phase %h (t=%0t)", e.ph, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

  initial begin : driver
    logic [15:0] bnd [8];
    bnd = '{16'h0000, 16'h4000, 16'hC000, 16'h8000, 16'h7FFF, 16'h3FFF, 16'hBFFF, 16'h4001};
    for (int k = 0; k < 64; k++) tab[k] = int'($floor($cos(PI * real'(k) / 128.0) * 32767.0 + 0.5));
    tab[64] = 0;

    reset = 1'b1;
    bus.ce = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0;
    bus.phase_in = '0; bus.freq = '0; bus.load = 1'b0;
    do_reset(3);

    // Quadrant corner points
    step_const(16'h0000, 16'h7FFF, 16'h0000);
    step_const(16'h4000, 16'h0000, 16'h7FFF);
    step_const(16'hC000, 16'h0000, 16'h8001);
    step_const(16'h8000, 16'h8001, 16'h0000);

    // Direct burst with random ce gaps; load must be ignored in mode 0
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ph;
      ph = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 7)] : 16'($urandom);
      step($urandom_range(0, 3) != 0, 1'b0, 1'($urandom_range(0, 1)), ph,
           16'($urandom), 1'($urandom_range(0, 1)));
    end

    // NCO: 64-sample period through the 0x7C00 -> 0x8000 wrap
    step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0400, 1'b1);
    for (int i = 0; i < 140; i++)
      step(1'b1, 1'b1, 1'b0, 16'($urandom), 16'h0400, 1'b0);
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 2) != 0, 1'b1, 1'b0, 16'($urandom), 16'h0400, 1'b0);

    // Mixed mode switching, random increments and loads
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom), 16'($urandom), $urandom_range(0, 5) == 0);

    // Reset two cycles after three valid samples: all of them are discarded
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'($urandom), 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    do_reset(2);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'($urandom), 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 16'($urandom), 16'h0, 1'b0);

    // Full phase sweep through the accumulator
    step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b1);
    for (int i = 0; i < 65536; i++)
      step(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    chk_int("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
